packet_transmitter: RTL and testbench
=====================================

Name: packet_transmitter

Overview:
- Output-port end of the router.
- Drains one destination FIFO, which is first-word-fall-through on the read side, and re-serialises the stored packet onto an 8-bit valid/ready output link.
- Regenerates packet framing, checks the parity byte, and drops a stalled packet after a timeout.
- One instance per port (3 total); each sits after the FIFO filled by the receiver.

Parameters:
- TIMEOUT, 30, consecutive stall cycles (vld_out=1, ready_in=0) before the packet is dropped.
- CW, 5, width of the stall counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk2  input  1  port clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- rempty  input  1  FIFO empty flag.
- rdata  input  8  FIFO head byte; valid when rempty=0.
- rinc  output  1  FIFO pop strobe; one byte per cycle.
- ready_in  input  1  downstream accepts data_out this cycle.
- vld_out  output  1  data_out holds a valid byte.
- data_out  output  8  output byte.
- sop_out  output  1  data_out is a header byte.
- eop_out  output  1  data_out is a parity byte.
- busy  output  1  a packet is in progress (state != IDLE).
- parity_err  output  1  1-cycle pulse: received parity != XOR of header and payload.
- timeout_drop  output  1  1-cycle pulse: packet dropped after a stall.

Behaviour:

Packet format:
- Byte 0 is the header: [1:0] destination, [7:2] payload length L (0..63).
- Then L payload bytes, then 1 parity byte.
- Total length is L+2 bytes.

Reset (rst=0):
- state=IDLE.
- rinc=0, vld_out=0, data_out=8'h00, sop_out=0, eop_out=0, busy=0, parity_err=0, timeout_drop=0.
- Byte counter, parity accumulator and stall counter all 0.
- Asserting reset mid-packet abandons the packet; the remaining FIFO bytes are not flushed.

Output register:
- `adv = ~vld_out | ready_in`.
- `load = adv & ~rempty & (state != FLUSH)`.
- On load: `rinc=1` in the same cycle (combinational), data_out<=rdata, vld_out<=1.
- On `adv & ~load`: vld_out<=0.
- Latency: a byte at the FIFO head appears on data_out 1 cycle after the pop.
- Sustained rate is 1 byte/cycle with ready_in held high.

States:
- IDLE: on load, take the byte as the header.
  - sop_out<=1, cnt<=rdata[7:2], par<=rdata.
  - Next state is PAYLOAD if rdata[7:2]!=0, else PARITY.
- PAYLOAD: on load, par<=par^rdata and cnt<=cnt-1.
  - When cnt==1 on load, go to PARITY.
- PARITY: on load, eop_out<=1.
  - If rdata != par, pulse parity_err. The byte is forwarded regardless.
  - Next state is IDLE.
- FLUSH: rinc=1 whenever rempty=0; vld_out=0.
  - cnt counts the remaining bytes, including parity.
  - When the last byte pops, go to IDLE.
- sop_out and eop_out update only on load and clear on any other adv.

Stall and timeout:
- stall counter increments while `vld_out & ~ready_in`; clears otherwise.
- When it reaches TIMEOUT, all of the following happen in that cycle:
  - vld_out<=0 and timeout_drop is pulsed.
  - If state is PAYLOAD or PARITY: go to FLUSH, with cnt = remaining bytes (PAYLOAD: cnt+1; PARITY: 1).
  - If the stalled byte was the parity byte (state already IDLE): stay IDLE; nothing to flush.
- If ready_in rises in the same cycle the count reaches TIMEOUT, ready_in wins: the byte is accepted and there is no drop.

FIFO empty mid-packet:
- Hold state; vld_out falls after the current byte is accepted.
- Resume when rempty deasserts. No timeout accrues while vld_out=0.

Never pops when rempty=1.

Test Plan:
- Reset: hold rst=0 with rempty=0 → rinc=0, vld_out=0, data_out=00. After release, header pops on the first posedge.
- Back-to-back: FIFO holds {0x09, 0xAA, 0x55, 0xF6}, then {0x02, 0x02}; ready_in=1 → 6 consecutive valid bytes; sop on 0x09 and 0x02, eop on 0xF6 and 0x02; no parity_err.
- Parity error: FIFO holds {0x05, 0x11, 0x00}; the correct parity would be 0x14 → all 3 bytes forwarded, parity_err pulses with eop_out.
- Backpressure: ready_in low for 5 cycles on byte 2 → data_out holds 0x55, rinc=0 throughout; resumes without loss.
- Timeout: 0x0D packet (L=3), ready_in=0 from the first payload byte for 30 cycles → timeout_drop pulse; the 3 remaining bytes are popped with vld_out=0; the next packet's header is emitted normally.
- Underflow: FIFO empty after header 0x04 → vld_out drops after the header is accepted; the payload byte is emitted 1 cycle after rempty falls; then parity.

Source files
------------

// File: rtl/packet_transmitter.sv
// ---------------------------------------------------------------------------
// packet_transmitter
//   Output-port end of the router. Drains one first-word-fall-through
//   destination FIFO and re-serialises each stored packet onto an 8-bit
//   valid/ready link, regenerating SOP/EOP framing, checking the trailing
//   parity byte and dropping a packet whose output byte stalls too long.
//
//   Packet: header {len[7:2], dest[1:0]}, len payload bytes, parity byte
//   (XOR of header and payload).
//
// Parameters
//   TIMEOUT      consecutive stall cycles (vld_out=1, ready_in=0) before drop
//   CW           stall counter width, 2**CW > TIMEOUT
//
// Ports
//   clk2         port clock, all logic on posedge
//   rst          asynchronous active-low reset
//   rempty       FIFO empty flag
//   rdata        FIFO head byte, valid while rempty=0
//   rinc         FIFO pop strobe (combinational, one byte per cycle)
//   ready_in     downstream accepts data_out this cycle
//   vld_out      data_out holds a valid byte
//   data_out     output byte
//   sop_out      data_out is a header byte
//   eop_out      data_out is a parity byte
//   busy         a packet is in progress
//   parity_err   1-cycle pulse, received parity mismatched
//   timeout_drop 1-cycle pulse, packet dropped after a stall
// ---------------------------------------------------------------------------
module packet_transmitter #(
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned CW      = 5
) (
  input  logic       clk2,
  input  logic       rst,
  input  logic       rempty,
  input  logic [7:0] rdata,
  output logic       rinc,
  input  logic       ready_in,
  output logic       vld_out,
  output logic [7:0] data_out,
  output logic       sop_out,
  output logic       eop_out,
  output logic       busy,
  output logic       parity_err,
  output logic       timeout_drop
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_PARITY,
    S_FLUSH
  } state_e;

  // Stall count value at which the next stalled cycle is the TIMEOUT-th one.
  localparam logic [CW-1:0] STALL_LAST = CW'(TIMEOUT - 1);

  state_e          state_q;
  logic [6:0]      cnt_q;     // payload bytes still to load, or bytes left to flush
  logic [7:0]      par_q;
  logic [CW-1:0]   stall_q;
  logic [CW-1:0]   stall_d;
  logic            vld_q;
  logic [7:0]      data_q;
  logic            sop_q;
  logic            eop_q;
  logic            perr_q;
  logic            drop_q;

  logic            adv;
  logic            load;
  logic            fpop;
  logic            stall;
  logic            drop;

  // The output register can take a new byte when empty or being accepted.
  // Both pop paths are gated by rst so nothing leaves the FIFO while the
  // port is held in reset.
  always_comb begin
    adv     = ~vld_q | ready_in;
    load    = rst & adv & ~rempty & (state_q != S_FLUSH);
    fpop    = rst & ~rempty & (state_q == S_FLUSH);
    stall   = vld_q & ~ready_in;
    drop    = stall & (stall_q == STALL_LAST);
    stall_d = '0;
    if (stall && !drop) begin
      stall_d = stall_q + CW'(1);
    end
  end

  assign rinc         = load | fpop;
  assign vld_out      = vld_q;
  assign data_out     = data_q;
  assign sop_out      = sop_q;
  assign eop_out      = eop_q;
  assign busy         = (state_q != S_IDLE);
  assign parity_err   = perr_q;
  assign timeout_drop = drop_q;

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      par_q   <= '0;
      stall_q <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      perr_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      perr_q  <= 1'b0;
      drop_q  <= 1'b0;
      stall_q <= stall_d;

      if (drop) begin
        // The stalled byte is already out of the FIFO; whatever is left of
        // its packet must be discarded. A stalled parity byte leaves
        // nothing behind, so IDLE stays IDLE.
        vld_q  <= 1'b0;
        sop_q  <= 1'b0;
        eop_q  <= 1'b0;
        drop_q <= 1'b1;
        case (state_q)
          S_PAYLOAD: begin
            state_q <= S_FLUSH;
            cnt_q   <= cnt_q + 7'd1;
          end
          S_PARITY: begin
            state_q <= S_FLUSH;
            cnt_q   <= 7'd1;
          end
          default: ;
        endcase
      end else if (load) begin
        vld_q  <= 1'b1;
        data_q <= rdata;
        sop_q  <= (state_q == S_IDLE);
        eop_q  <= (state_q == S_PARITY);
        case (state_q)
          S_IDLE: begin
            cnt_q   <= {1'b0, rdata[7:2]};
            par_q   <= rdata;
            state_q <= (rdata[7:2] != 6'd0) ? S_PAYLOAD : S_PARITY;
          end
          S_PAYLOAD: begin
            par_q <= par_q ^ rdata;
            cnt_q <= cnt_q - 7'd1;
            if (cnt_q == 7'd1) begin
              state_q <= S_PARITY;
            end
          end
          S_PARITY: begin
            perr_q  <= (rdata != par_q);
            state_q <= S_IDLE;
          end
          default: ;
        endcase
      end else if (adv) begin
        vld_q <= 1'b0;
        sop_q <= 1'b0;
        eop_q <= 1'b0;
      end

      // Flushing never coincides with load or drop (vld_out is already low).
      if (fpop) begin
        cnt_q <= cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          state_q <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_packet_transmitter.sv
// ---------------------------------------------------------------------------
// tb_packet_transmitter
//   Directed bench for packet_transmitter. A bench-side FWFT FIFO feeds the
//   DUT; a packet-level model lists the bytes that must cross the output
//   link (with SOP/EOP/bad-parity flags) and a per-cycle compare process
//   checks every accepted byte against it. Literal checks pin timing points.
// ---------------------------------------------------------------------------
module tb_packet_transmitter;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       bad;
  } exp_t;

  logic       clk2     = 1'b0;
  logic       rst      = 1'b1;
  logic       rempty   = 1'b1;
  logic [7:0] rdata    = 8'hEE;
  logic       ready_in = 1'b1;
  logic       rinc;
  logic       vld_out;
  logic [7:0] data_out;
  logic       sop_out;
  logic       eop_out;
  logic       busy;
  logic       parity_err;
  logic       timeout_drop;

  int n_tests     = 0;
  int n_fail      = 0;
  int n_perr_seen = 0;
  int n_perr_exp  = 0;
  int n_drop_seen = 0;

  logic [7:0] fifo[$];
  exp_t       exp_q[$];
  logic       fifo_pop;

  always #5 clk2 = ~clk2;

  packet_transmitter #(.TIMEOUT(30), .CW(5)) dut (
    .clk2         (clk2),
    .rst          (rst),
    .rempty       (rempty),
    .rdata        (rdata),
    .rinc         (rinc),
    .ready_in     (ready_in),
    .vld_out      (vld_out),
    .data_out     (data_out),
    .sop_out      (sop_out),
    .eop_out      (eop_out),
    .busy         (busy),
    .parity_err   (parity_err),
    .timeout_drop (timeout_drop)
  );

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired before the expected event", name);
  endtask

  // Model: parity is the XOR of every byte before the last one.
  function automatic logic [7:0] model_par(input bq_t p);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < p.size() - 1; i++) x ^= p[i];
    return x;
  endfunction

  function automatic int pkt_len(input logic [7:0] hdr);
    return int'(hdr[7:2]) + 2;
  endfunction

  // Queue the first 'deliver' bytes of packet p as expected link transfers.
  task automatic expect_pkt(input bq_t p, input int deliver);
    exp_t e;
    logic bad;
    bad = (p[p.size() - 1] != model_par(p));
    for (int i = 0; i < deliver; i++) begin
      e.d   = p[i];
      e.sop = (i == 0);
      e.eop = (i == p.size() - 1);
      e.bad = bad;
      exp_q.push_back(e);
    end
    if (deliver == p.size() && bad) n_perr_exp++;
  endtask

  task automatic push_fifo(input bq_t p);
    foreach (p[i]) fifo.push_back(p[i]);
  endtask

  task automatic step();
    @(posedge clk2);
    #2;
  endtask

  task automatic compare_cycle();
    exp_t e;
    if (rst) begin
      if (rempty) chk("no_pop_when_empty", rinc, 0);
      if (timeout_drop) n_drop_seen++;
      if (parity_err) begin
        n_perr_seen++;
        chk("perr_with_eop", eop_out & vld_out, 1);
        if (exp_q.size() > 0) chk("perr_expected", exp_q[0].bad & exp_q[0].eop, 1);
        else begin
          n_tests++; n_fail++;
          $display("FAIL perr_expected: pulse with no expected byte, got 1 expected 0");
        end
      end
      if (vld_out && ready_in) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL extra_byte: got 0x%0h, expected no transfer", data_out);
        end else begin
          e = exp_q.pop_front();
          chk("stream_data", data_out, e.d);
          chk("stream_sop", sop_out, e.sop);
          chk("stream_eop", eop_out, e.eop);
        end
      end
    end
  endtask

  task automatic wait_data(input logic [7:0] b, input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (vld_out && data_out == b) begin
        found = 1;
        break;
      end
      step();
    end
    if (found) chk(name, data_out, b);
    else fail(name);
  endtask

  task automatic wait_eop(input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (vld_out && eop_out) begin
        found = 1;
        break;
      end
      step();
    end
    if (found) chk(name, eop_out, 1);
    else fail(name);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && fifo.size() == 0 && !vld_out && !busy) begin
        done = 1;
        break;
      end
      step();
    end
    if (done) chk(name, busy, 0);
    else fail(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t        p;
    logic [7:0] bb_d[6];
    logic [5:0] bb_sop;
    logic [5:0] bb_eop;

    bb_d   = '{8'h09, 8'hAA, 8'h55, 8'hF6, 8'h02, 8'h02};
    bb_sop = 6'b010001;
    bb_eop = 6'b101000;

    fork
      // FWFT FIFO: pop what the DUT popped, then present the new head.
      forever begin
        @(negedge clk2);
        fifo_pop = rinc;
        @(posedge clk2);
        #1;
        if (fifo_pop && fifo.size() > 0) void'(fifo.pop_front());
        rempty = (fifo.size() == 0);
        rdata  = rempty ? 8'hEE : fifo[0];
      end
      forever begin
        @(negedge clk2);
        compare_cycle();
      end
    join_none

    #1 rst = 1'b0;

    // Pin the model against hand-computed values.
    p = '{8'h09, 8'hAA, 8'h55, 8'hF6};
    chk("model_par_09", model_par(p), 8'hF6);
    p = '{8'h05, 8'h11, 8'h00};
    chk("model_par_05", model_par(p), 8'h14);
    p = '{8'h0D, 8'h21, 8'h42, 8'h84, 8'hEA};
    chk("model_par_0D", model_par(p), 8'hEA);
    chk("model_len_0D", pkt_len(8'h0D), 5);

    // Reset with a non-empty FIFO: no pop, outputs at reset values.
    p = '{8'h02, 8'h02};
    expect_pkt(p, 2);
    push_fifo(p);
    step(); step(); step();
    chk("rst_rinc", rinc, 0);
    chk("rst_vld", vld_out, 0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_sop", sop_out, 0);
    chk("rst_eop", eop_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_drop", timeout_drop, 0);
    rst = 1'b1;
    #1;
    chk("release_rinc", rinc, 1);
    step();
    chk("first_hdr_vld", vld_out, 1);
    chk("first_hdr_data", data_out, 8'h02);
    chk("first_hdr_sop", sop_out, 1);
    chk("first_hdr_busy", busy, 1);
    wait_idle("reset_pkt_idle");

    // Back-to-back packets at one byte per cycle.
    p = '{8'h09, 8'hAA, 8'h55, 8'hF6};
    expect_pkt(p, 4);
    push_fifo(p);
    p = '{8'h02, 8'h02};
    expect_pkt(p, 2);
    push_fifo(p);
    wait_data(8'h09, "b2b_start");
    for (int i = 0; i < 6; i++) begin
      chk("b2b_vld", vld_out, 1);
      chk("b2b_data", data_out, bb_d[i]);
      chk("b2b_sop", sop_out, bb_sop[i]);
      chk("b2b_eop", eop_out, bb_eop[i]);
      chk("b2b_no_perr", parity_err, 0);
      step();
    end
    wait_idle("b2b_idle");
    chk("b2b_perr_count", n_perr_seen, 0);

    // Bad parity byte is forwarded and flagged.
    p = '{8'h05, 8'h11, 8'h00};
    expect_pkt(p, 3);
    push_fifo(p);
    wait_eop("perr_eop");
    chk("perr_pulse", parity_err, 1);
    chk("perr_data", data_out, 8'h00);
    step();
    chk("perr_one_cycle", parity_err, 0);
    wait_idle("perr_idle");

    // Backpressure on byte 2 for five cycles.
    p = '{8'h09, 8'hAA, 8'h55, 8'hF6};
    expect_pkt(p, 4);
    push_fifo(p);
    wait_data(8'h55, "bp_byte2");
    ready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_hold_data", data_out, 8'h55);
      chk("bp_hold_vld", vld_out, 1);
      chk("bp_no_pop", rinc, 0);
      step();
    end
    ready_in = 1'b1;
    wait_idle("bp_idle");

    // Payload stall of exactly TIMEOUT cycles: drop, flush 3 bytes.
    p = '{8'h0D, 8'h21, 8'h42, 8'h84, 8'hEA};
    expect_pkt(p, 1);
    push_fifo(p);
    wait_data(8'h21, "to_payload1");
    ready_in = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 29) begin
        chk("to_before_vld", vld_out, 1);
        chk("to_before_drop", timeout_drop, 0);
      end
    end
    chk("to_drop_pulse", timeout_drop, 1);
    chk("to_vld_low", vld_out, 0);
    chk("to_busy_flush", busy, 1);
    ready_in = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk("to_flush_pop", rinc, 1);
      chk("to_flush_vld", vld_out, 0);
      step();
    end
    chk("to_flush_done", busy, 0);
    p = '{8'h02, 8'h02};
    expect_pkt(p, 2);
    push_fifo(p);
    wait_idle("to_next_idle");

    // ready_in returns in the would-be TIMEOUT-th cycle: no drop.
    p = '{8'h05, 8'h77, 8'h72};
    expect_pkt(p, 3);
    push_fifo(p);
    wait_data(8'h77, "rw_payload");
    ready_in = 1'b0;
    for (int i = 0; i < 29; i++) step();
    ready_in = 1'b1;
    #1;
    chk("rw_vld", vld_out, 1);
    chk("rw_data", data_out, 8'h77);
    chk("rw_no_drop_a", timeout_drop, 0);
    step();
    chk("rw_no_drop_b", timeout_drop, 0);
    wait_idle("rw_idle");

    // Stall on the parity byte: drop, stay idle, nothing to flush.
    p = '{8'h02, 8'h02};
    expect_pkt(p, 1);
    push_fifo(p);
    wait_eop("ps_eop");
    ready_in = 1'b0;
    for (int i = 0; i < 30; i++) step();
    chk("ps_drop_pulse", timeout_drop, 1);
    chk("ps_vld_low", vld_out, 0);
    chk("ps_busy", busy, 0);
    ready_in = 1'b1;
    step();
    chk("ps_vld_after", vld_out, 0);
    wait_idle("ps_idle");

    // FIFO underflow after the header.
    p = '{8'h04, 8'h33, 8'h37};
    expect_pkt(p, 3);
    p = '{8'h04};
    push_fifo(p);
    wait_data(8'h04, "uf_hdr");
    step();
    chk("uf_vld_low_a", vld_out, 0);
    chk("uf_busy", busy, 1);
    step();
    chk("uf_vld_low_b", vld_out, 0);
    p = '{8'h33, 8'h37};
    push_fifo(p);
    step();
    chk("uf_vld_low_c", vld_out, 0);
    step();
    chk("uf_pay_vld", vld_out, 1);
    chk("uf_pay_data", data_out, 8'h33);
    chk("uf_pay_sop", sop_out, 0);
    step();
    chk("uf_par_data", data_out, 8'h37);
    chk("uf_par_eop", eop_out, 1);
    wait_idle("uf_idle");

    step();
    chk("end_exp_empty", exp_q.size(), 0);
    chk("end_perr_count", n_perr_seen, n_perr_exp);
    chk("end_drop_count", n_drop_seen, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
